// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the FSM encoding, requester id type and the legal-address helper.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_R0 = 1'b0;
    localparam req_id_t REQ_R1 = 1'b1;

    // 1024-word data memory: first byte address that is out of range.
    localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_1000;

    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] limit);
        return (addr < limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave view belongs to the arbiter; the master view to requesters and memory.
interface dmem_arbiter_if;

    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_we;
    logic        r0_rsp_valid;

    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_we;
    logic        r1_rsp_valid;

    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  r0_valid, r0_addr, r0_wdata, r0_we,
        input  r1_valid, r1_addr, r1_wdata, r1_we,
        output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        output rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );

    modport master (
        output r0_valid, r0_addr, r0_wdata, r0_we,
        output r1_valid, r1_addr, r1_wdata, r1_we,
        input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
        input  rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, and under
// contention the requester that did not win last time is granted.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant == REQ_R1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the CPU data port (r0) and the loader/debug port (r1) onto a
// single data memory: accept in IDLE, access in ISSUE, respond the cycle after.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic           clock,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);

    arb_state_t  state;
    req_id_t     last_grant;
    logic [1:0]  grant;
    logic        accept0;
    logic        accept1;
    logic        accept;

    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_we;
    req_id_t     cmd_id;
    logic        cmd_legal;
    logic        issue_ok;

    logic        rsp0_q;
    logic        rsp1_q;
    logic [31:0] rdata_q;
    logic        err_q;

    rr_arb2 u_rr_arb2 (
        .valid      ({bus.r1_valid, bus.r0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign bus.r0_ready = reset_n && (state == IDLE) && grant[0];
    assign bus.r1_ready = reset_n && (state == IDLE) && grant[1];
    assign accept0      = bus.r0_valid && bus.r0_ready;
    assign accept1      = bus.r1_valid && bus.r1_ready;
    assign accept       = accept0 || accept1;

    assign cmd_legal     = addr_legal(cmd_addr, ADDR_LIMIT);
    assign bus.mem_addr  = cmd_addr;
    assign bus.mem_wdata = cmd_wdata;

    // Strobes are gated by reset_n directly so a reset landing on the
    // access cycle cannot let a write slip into memory.
    assign issue_ok      = reset_n && (state == ISSUE) && cmd_legal;
    assign bus.mem_write = issue_ok && cmd_we;
    assign bus.mem_read  = issue_ok && !cmd_we;

    assign bus.r0_rsp_valid = rsp0_q;
    assign bus.r1_rsp_valid = rsp1_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_err      = err_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= REQ_R1;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_we     <= 1'b0;
            cmd_id     <= REQ_R0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    state      <= ISSUE;
                    last_grant <= accept1 ? REQ_R1 : REQ_R0;
                    cmd_id     <= accept1 ? REQ_R1 : REQ_R0;
                    cmd_addr   <= accept1 ? bus.r1_addr  : bus.r0_addr;
                    cmd_wdata  <= accept1 ? bus.r1_wdata : bus.r0_wdata;
                    cmd_we     <= accept1 ? bus.r1_we    : bus.r0_we;
                end
            end else begin
                // Read data is sampled on the access cycle; writes and
                // illegal commands report zero data.
                state   <= IDLE;
                rsp0_q  <= (cmd_id == REQ_R0);
                rsp1_q  <= (cmd_id == REQ_R1);
                rdata_q <= (cmd_legal && !cmd_we) ? bus.mem_rdata : 32'h0;
                err_q   <= !cmd_legal;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural
// data memory and a per-cycle protocol monitor.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset_n;
    int          compared;
    int          mismatched;
    logic        mon_en;

    logic [31:0] mem [0:1023];
    logic        load_we;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    logic        p0_1, p0_2, p1_1, p1_2;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.ADDR_LIMIT(32'h0000_1000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    always @(posedge clock) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end else if (load_we) begin
            mem[load_idx] <= load_data;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic [31:0] a0, input logic [31:0] d0, input logic w0,
                                  input logic v1, input logic [31:0] a1, input logic [31:0] d1, input logic w1);
        bus.r0_valid = v0;
        bus.r0_addr  = a0;
        bus.r0_wdata = d0;
        bus.r0_we    = w0;
        bus.r1_valid = v1;
        bus.r1_addr  = a1;
        bus.r1_wdata = d1;
        bus.r1_we    = w1;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        load_we   = 1'b1;
        load_idx  = idx;
        load_data = data;
        next_cycle();
        load_we   = 1'b0;
    endtask

    // Protocol monitor: one response exactly two cycles after each surviving
    // accept, exclusive readies/responses, strobes only on the access cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            check_output("mon_one_rsp", {31'h0, bus.r0_rsp_valid && bus.r1_rsp_valid}, 32'h0);
            check_output("mon_one_ready", {31'h0, bus.r0_ready && bus.r1_ready}, 32'h0);
            check_output("mon_rsp0_per_accept", {31'h0, bus.r0_rsp_valid}, {31'h0, p0_2});
            check_output("mon_rsp1_per_accept", {31'h0, bus.r1_rsp_valid}, {31'h0, p1_2});
            check_output("mon_strobe_idle", {31'h0, (bus.mem_read || bus.mem_write) && !(p0_1 || p1_1)}, 32'h0);
            p0_2 = p0_1 && reset_n;
            p1_2 = p1_1 && reset_n;
            p0_1 = bus.r0_valid && bus.r0_ready && reset_n;
            p1_1 = bus.r1_valid && bus.r1_ready && reset_n;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clock      = 1'b0;
        reset_n    = 1'b0;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        load_we    = 1'b0;
        load_idx   = '0;
        load_data  = '0;
        p0_1 = 1'b0; p0_2 = 1'b0; p1_1 = 1'b0; p1_2 = 1'b0;
        apply_idle();
        next_cycle();
        mon_en = 1'b1;

        // Reset state, with r0 already requesting
        apply_stimulus(1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        check_output("reset_r0_ready", {31'h0, bus.r0_ready}, 32'h0);
        check_output("reset_r1_ready", {31'h0, bus.r1_ready}, 32'h0);
        check_output("reset_rsp0", {31'h0, bus.r0_rsp_valid}, 32'h0);
        check_output("reset_rdata", bus.rsp_rdata, 32'h0);
        check_output("reset_err", {31'h0, bus.rsp_err}, 32'h0);
        check_output("reset_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        next_cycle();
        load_word(10'h040, 32'h1234_5678);
        load_word(10'h000, 32'hFFFF_FFFF);
        load_word(10'h020, 32'h1111_1111);
        load_word(10'h080, 32'hA0A0_0200);
        load_word(10'h081, 32'hB1B1_0204);

        $display("[TB] single read");
        reset_n = 1'b1;
        apply_stimulus(1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        check_output("rd_r0_ready", {31'h0, bus.r0_ready}, 32'h1);
        check_output("rd_r1_ready", {31'h0, bus.r1_ready}, 32'h0);
        check_output("rd_no_early_read", {31'h0, bus.mem_read}, 32'h0);
        next_cycle();
        apply_idle();
        @(negedge clock);
        check_output("rd_mem_read", {31'h0, bus.mem_read}, 32'h1);
        check_output("rd_mem_write", {31'h0, bus.mem_write}, 32'h0);
        check_output("rd_mem_addr", bus.mem_addr, 32'h100);
        check_output("rd_r0_ready_issue", {31'h0, bus.r0_ready}, 32'h0);
        next_cycle();
        @(negedge clock);
        check_output("rd_rsp0", {31'h0, bus.r0_rsp_valid}, 32'h1);
        check_output("rd_rdata", bus.rsp_rdata, 32'h1234_5678);
        check_output("rd_err", {31'h0, bus.rsp_err}, 32'h0);
        next_cycle();

        $display("[TB] contention");
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        apply_stimulus(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 32'h204, 32'h0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (k % 2 == 0) begin
                check_output("ct_r0_ready", {31'h0, bus.r0_ready}, {31'h0, ((k / 2) % 2) == 0});
                check_output("ct_r1_ready", {31'h0, bus.r1_ready}, {31'h0, ((k / 2) % 2) == 1});
            end else begin
                check_output("ct_ready_issue", {30'h0, bus.r1_ready, bus.r0_ready}, 32'h0);
            end
            if (k >= 2 && k % 2 == 0) begin
                check_output("ct_rdata", bus.rsp_rdata, (((k - 2) / 2) % 2 == 0) ? 32'hA0A0_0200 : 32'hB1B1_0204);
            end
            next_cycle();
        end
        apply_idle();
        @(negedge clock);
        check_output("ct_last_rsp1", {31'h0, bus.r1_rsp_valid}, 32'h1);
        check_output("ct_last_rdata", bus.rsp_rdata, 32'hB1B1_0204);
        next_cycle();

        $display("[TB] write then read");
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1);
        @(negedge clock);
        check_output("wr_r1_ready", {31'h0, bus.r1_ready}, 32'h1);
        next_cycle();
        apply_idle();
        @(negedge clock);
        check_output("wr_mem_write", {31'h0, bus.mem_write}, 32'h1);
        check_output("wr_mem_read", {31'h0, bus.mem_read}, 32'h0);
        check_output("wr_mem_addr", bus.mem_addr, 32'h40);
        check_output("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        apply_stimulus(1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        check_output("wr_rsp1", {31'h0, bus.r1_rsp_valid}, 32'h1);
        check_output("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_output("wr_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        check_output("wr_r0_ready_overlap", {31'h0, bus.r0_ready}, 32'h1);
        next_cycle();
        apply_idle();
        @(negedge clock);
        check_output("rb_mem_read", {31'h0, bus.mem_read}, 32'h1);
        next_cycle();
        @(negedge clock);
        check_output("rb_rsp0", {31'h0, bus.r0_rsp_valid}, 32'h1);
        check_output("rb_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        next_cycle();

        $display("[TB] illegal addresses");
        apply_stimulus(1'b1, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        check_output("il_r0_ready", {31'h0, bus.r0_ready}, 32'h1);
        next_cycle();
        apply_idle();
        @(negedge clock);
        check_output("il_r0_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h102, 32'h5555_5555, 1'b1);
        @(negedge clock);
        check_output("il_rsp0", {31'h0, bus.r0_rsp_valid}, 32'h1);
        check_output("il_rsp0_err", {31'h0, bus.rsp_err}, 32'h1);
        check_output("il_rsp0_rdata", bus.rsp_rdata, 32'h0);
        check_output("il_r1_ready", {31'h0, bus.r1_ready}, 32'h1);
        next_cycle();
        apply_idle();
        @(negedge clock);
        check_output("il_r1_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        next_cycle();
        @(negedge clock);
        check_output("il_rsp1", {31'h0, bus.r1_rsp_valid}, 32'h1);
        check_output("il_rsp1_err", {31'h0, bus.rsp_err}, 32'h1);
        check_output("il_rsp1_rdata", bus.rsp_rdata, 32'h0);
        check_output("il_mem_untouched", mem[10'h040], 32'h1234_5678);
        next_cycle();

        $display("[TB] reset during access");
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hAAAA_AAAA, 1'b1);
        @(negedge clock);
        check_output("rs_r1_ready", {31'h0, bus.r1_ready}, 32'h1);
        next_cycle();
        apply_idle();
        reset_n = 1'b0;
        @(negedge clock);
        check_output("rs_mem_write", {31'h0, bus.mem_write}, 32'h0);
        next_cycle();
        reset_n = 1'b1;
        apply_stimulus(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 32'h204, 32'h0, 1'b0);
        @(negedge clock);
        check_output("rs_no_rsp", {30'h0, bus.r1_rsp_valid, bus.r0_rsp_valid}, 32'h0);
        check_output("rs_mem_kept", mem[10'h020], 32'h1111_1111);
        check_output("rs_r0_wins", {31'h0, bus.r0_ready}, 32'h1);
        check_output("rs_r1_waits", {31'h0, bus.r1_ready}, 32'h0);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h204, 32'h0, 1'b0);
        @(negedge clock);
        check_output("rs_issue_read", {31'h0, bus.mem_read}, 32'h1);
        next_cycle();
        @(negedge clock);
        check_output("rs_rsp0_rdata", bus.rsp_rdata, 32'hA0A0_0200);
        check_output("rs_r1_ready_next", {31'h0, bus.r1_ready}, 32'h1);
        next_cycle();
        apply_idle();
        next_cycle();
        @(negedge clock);
        check_output("rs_rsp1_rdata", bus.rsp_rdata, 32'hB1B1_0204);
        next_cycle();
        next_cycle();
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_LIMIT, 32'h0000_1000, first illegal byte address (1024-word data memory).
REQ-002 Port: clock  in  1  single clock; all state updates on posedge.
REQ-003 Port: reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
REQ-004 Port: r0_valid / r1_valid  in  1 each  request present (r0 = CPU data port, r1 = loader/debug port).
REQ-005 Port: r0_ready / r1_ready  out  1 each  request accepted this cycle when valid && ready.
REQ-006 Port: r0_addr / r1_addr  in  32 each  byte address.
REQ-007 Port: r0_wdata / r1_wdata  in  32 each  write data.
REQ-008 Port: r0_we / r1_we  in  1 each  1 = write, 0 = read.
REQ-009 Port: r0_rsp_valid / r1_rsp_valid  out  1 each  one-cycle response pulse.
REQ-010 Port: rsp_rdata  out  32  read data, shared by both requesters and qualified by rN_rsp_valid.
REQ-011 Port: rsp_err  out  1  error flag, qualified by rN_rsp_valid.
REQ-012 Port: mem_addr, mem_wdata  out  32 each  memory address and write data.
REQ-013 Port: mem_write, mem_read  out  1 each  memory strobes.
REQ-014 Port: mem_rdata  in  32  combinational read data from memory; write occurs at posedge.

Function
REQ-015 FSM states: IDLE, ISSUE.
- IDLE -> ISSUE on any accept.
- ISSUE -> IDLE unconditionally.
REQ-016 Ready: in IDLE, rN_ready = rN_valid && granted(N). In ISSUE, both readies are 0.
REQ-017 Grant when only one requester is valid: that requester is granted.
REQ-018 Grant when both are valid: the requester not in last_grant wins. last_grant updates on every accept.
REQ-019 Accept latches addr, wdata, we and requester id into a command register.
REQ-020 In ISSUE, mem_addr and mem_wdata are driven from the command register.
- mem_write = we && legal.
- mem_read = !we && legal.
REQ-021 In IDLE, mem_write = mem_read = 0. mem_addr and mem_wdata hold their last value.
REQ-022 Legal means addr < ADDR_LIMIT (unsigned compare) and addr[1:0] == 2'b00.
- An illegal command drives no strobe.
REQ-023 On the cycle after ISSUE, exactly one rsp_valid pulses, for the latched requester id.
- rsp_rdata = mem_rdata captured in ISSUE for a legal read, otherwise 0.
- rsp_err = !legal.
REQ-024 Latency: accept at edge N, memory access in cycle N+1, response visible in cycle N+2.
- Maximum throughput is one accept per 2 cycles.
- A new accept may coincide with a response cycle.
REQ-025 Writes also produce a response pulse, with rsp_rdata = 0.
REQ-026 A requester must hold valid and its fields stable until ready. The arbiter never drops an unaccepted request.
REQ-027 Both rsp_valid outputs are never high in the same cycle.

Reset
REQ-028 While reset_n = 0 at a posedge, the following take effect on that edge:
- state = IDLE; last_grant = r1, so r0 wins the first contention.
- Command register cleared.
- Both rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 mem_write and mem_read are gated combinationally by reset_n, so reset asserted during ISSUE suppresses that memory write.
REQ-030 Both ready outputs are 0 while reset_n = 0.
REQ-031 A transaction interrupted by reset produces no response.

Structure
REQ-032 Shared package dmem_arb_pkg holds:
- The state enum (IDLE, ISSUE).
- The requester-id typedef (1 bit).
- The ADDR_LIMIT default constant.
REQ-033 The 2-way round-robin picker is a sub-module rr_arb2.
- Inputs: valid[1:0], last_grant.
- Output: one-hot grant[1:0].
- Purely combinational.
REQ-034 All other logic lives in dmem_arbiter. No memory array lives inside this block.

Verification
REQ-035 Single read: r0 reads 0x100, memory holds 0x1234_5678 -> r0_ready at accept, mem_read in the next cycle, r0_rsp_valid with rsp_rdata 0x1234_5678 and rsp_err = 0 two cycles after accept.
REQ-036 Contention: r0 and r1 held valid continuously for 6 accepts -> grant order r0, r1, r0, r1, r0, r1, one accept every 2 cycles.
REQ-037 Write then read: r1 writes 0xDEAD_BEEF to 0x40, then r0 reads 0x40 -> r1 response with rdata 0, then r0 response with rdata 0xDEAD_BEEF.
REQ-038 Illegal addresses: r0 reads 0x1000 and r1 writes 0x102 -> no mem_read or mem_write pulse for either, and each response has rsp_err = 1 and rdata 0.
REQ-039 Reset mid-operation: reset_n low during the ISSUE cycle of an r1 write of 0xAAAA_AAAA to 0x80 -> mem_write stays 0, the word at 0x80 is unchanged, no response is issued, and the first post-reset contention is won by r0.
REQ-040 Assertions run in every test: at most one rsp_valid per cycle; at most one ready per cycle; no mem strobe in IDLE; exactly one response per accept.
